calc_datapath: RTL and testbench
================================

CALC_DATAPATH -- requirements
Module: calc_datapath

Interface
REQ-001 Parameter: WIDTH, default 8, operand width; RESULT is 2*WIDTH bits.
REQ-002 CLK  input  1  single system clock; all state updates on rising edge.
REQ-003 CLR  input  1  asynchronous, active-low reset.
REQ-004 SW  input  WIDTH  operand data from switches.
REQ-005 LdA  input  1  load SW into operand register A.
REQ-006 LdB  input  1  load SW into operand register B.
REQ-007 OP  input  4  one-hot opcode: 0001 ADD, 0010 SUB, 0100 MUL, 1000 DIV, 0000 none.
REQ-008 START_MUL  input  1  level request for multiply, held high by the controller.
REQ-009 START_DIV  input  1  level request for divide, held high by the controller.
REQ-010 RESULT  output  2*WIDTH  registered result.
REQ-011 BUSY  output  1  high while an iterative multiply or divide is running.
REQ-012 DONE  output  1  high while RESULT is valid for the current OP.
REQ-013 NEG  output  1  SUB result is negative (A<B).
REQ-014 DIV0  output  1  divide attempted with B==0.

Function
REQ-015 LdA=1 at a clock edge shall load A<=SW; LdB=1 shall load B<=SW; both loads shall occur if both are high; loads are ignored while BUSY=1.
REQ-016 States shall be IDLE, ARITH, MULT, DIVD and HOLD.
REQ-017 IDLE: OP=0001 or 0010 -> ARITH; rising edge of START_MUL with OP=0100 -> MULT; rising edge of START_DIV with OP=1000 -> DIVD; otherwise stay IDLE.
REQ-018 A start is a rising edge only: a 0-to-1 transition versus the previous cycle's registered value.
REQ-019 ARITH shall last one cycle, register the result, then go to HOLD; ADD latency from OP valid to DONE=1 is 2 edges.
REQ-020 ADD shall produce RESULT = zero-extended A+B, with the carry in bit WIDTH.
REQ-021 SUB shall produce RESULT = A-B sign-extended to 2*WIDTH two's complement, and set NEG=1 iff A<B.
REQ-022 MULT shall copy A and B into working registers on entry and run unsigned shift-add for exactly WIDTH cycles with BUSY=1; it then registers RESULT=A*B and goes to HOLD.
REQ-023 DIVD shall run an unsigned restoring divide for exactly WIDTH cycles with BUSY=1, then register RESULT={remainder[WIDTH-1:0], quotient[WIDTH-1:0]} and go to HOLD.
REQ-024 DIVD with B==0 shall skip iteration and BUSY, set DIV0=1 and RESULT all-ones, and enter HOLD on the next edge.
REQ-025 HOLD: DONE=1 and RESULT, NEG and DIV0 are held stable; OP=0000 -> IDLE with DONE=0 and RESULT retained.
REQ-026 An OP change in HOLD to another valid code shall return the block to IDLE, then re-dispatch under REQ-017.
REQ-027 OP, START_* and SW changes during MULT/DIVD shall be ignored until completion.
REQ-028 An OP value that is not one-hot and not zero shall be treated as 0000.
REQ-029 NEG shall be 0 for all operations except SUB; DIV0 shall be 0 except under REQ-024.

Reset
REQ-030 CLR=0 shall immediately force state=IDLE, A=B=0, working registers=0, RESULT=0, and BUSY, DONE, NEG, DIV0 and the start-edge registers to 0, regardless of the operation in progress.
REQ-031 After CLR deasserts, a held-high START_* shall not trigger until it goes low and high again.

Structure
REQ-032 Package calc_pkg shall hold the OP one-hot constants, the state enum and the default WIDTH.
REQ-033 The restoring divider shall be the sub-module seq_divider (start/busy/done handshake); the multiplier stays inline.

Verification
REQ-034 A=25, B=17, OP=0001 -> RESULT=16'd42, DONE=1 two edges after OP, NEG=0.
REQ-035 A=5, B=9, OP=0010 -> RESULT=16'hFFFC, NEG=1, DONE=1.
REQ-036 A=200, B=150, OP=0100, START_MUL 0->1 -> BUSY=1 for exactly 8 cycles, then RESULT=16'h7530, DONE=1.
REQ-037 A=200, B=7, OP=1000, START_DIV 0->1 -> after 8 BUSY cycles RESULT=16'h041C, DIV0=0.
REQ-038 A=9, B=0, DIV started -> BUSY never 1, DIV0=1, RESULT=16'hFFFF, DONE next edge.
REQ-039 CLR=0 at the 4th MUL cycle -> all outputs 0 immediately; after release START_MUL held high gives no start; a fresh 0->1 gives a correct product.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared opcode constants, controller state encoding and default operand width
// for the calculator datapath and its divider.
package calc_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [3:0] OP_NONE = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0100;
  localparam logic [3:0] OP_DIV  = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARITH = 3'd1,
    ST_MULT  = 3'd2,
    ST_DIVD  = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  // Anything other than a single recognised one-hot code behaves as "no operation".
  function automatic logic [3:0] op_sanitize(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV: return op;
      default:                        return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider: one quotient bit per clock for WIDTH clocks.
// done and the quotient/remainder outputs are valid together on the final iteration cycle.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] rem_reg, quo_reg, dvs_reg;
  logic [WIDTH-1:0] rem_next, quo_next;
  logic [CW-1:0]    cnt_reg;
  logic             busy_reg;
  logic [WIDTH:0]   rem_shift, trial;

  // The quotient register doubles as the dividend shift register.
  always_comb begin
    rem_shift = {rem_reg, quo_reg[WIDTH-1]};
    trial     = rem_shift - {1'b0, dvs_reg};
    rem_next  = trial[WIDTH] ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_next  = {quo_reg[WIDTH-2:0], ~trial[WIDTH]};
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      rem_reg  <= '0;
      quo_reg  <= '0;
      dvs_reg  <= '0;
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
    end else if (start && !busy_reg) begin
      rem_reg  <= '0;
      quo_reg  <= dividend;
      dvs_reg  <= divisor;
      cnt_reg  <= '0;
      busy_reg <= 1'b1;
    end else if (busy_reg) begin
      rem_reg <= rem_next;
      quo_reg <= quo_next;
      cnt_reg <= cnt_reg + 1'b1;
      if (cnt_reg == LAST) busy_reg <= 1'b0;
    end
  end

  assign busy      = busy_reg;
  assign done      = busy_reg && (cnt_reg == LAST);
  assign quotient  = quo_next;
  assign remainder = rem_next;

endmodule

// File: rtl/calc_datapath.sv
// Calculator datapath: operand registers, single-cycle add/subtract, iterative
// shift-add multiply and restoring divide, with a hold-until-opcode-changes result.
module calc_datapath
  import calc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               CLK,
  input  logic               CLR,
  input  logic [WIDTH-1:0]   SW,
  input  logic               LdA,
  input  logic               LdB,
  input  logic [3:0]         OP,
  input  logic               START_MUL,
  input  logic               START_DIV,
  output logic [2*WIDTH-1:0] RESULT,
  output logic               BUSY,
  output logic               DONE,
  output logic               NEG,
  output logic               DIV0
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t             state_reg;
  logic [WIDTH-1:0]   a_reg, b_reg;
  logic [3:0]         op_reg;
  logic               mul_prev_reg, div_prev_reg;
  logic               mul_armed_reg, div_armed_reg;
  logic [2*WIDTH-1:0] mcand_reg, acc_reg, result_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [CW-1:0]      mcnt_reg;
  logic               mul_busy_reg, done_reg, neg_reg, div0_reg;

  logic [3:0]         op_eff;
  logic               mul_rise, div_rise, div_start;
  logic               div_busy, div_done;
  logic [WIDTH-1:0]   div_quo, div_rem;
  logic [WIDTH:0]     sum_w, diff_w;
  logic [2*WIDTH-1:0] acc_next;

  // A start only counts once the request has been seen low since reset,
  // so a level still held high across reset cannot fire.
  always_comb begin
    op_eff    = op_sanitize(OP);
    mul_rise  = START_MUL && !mul_prev_reg && mul_armed_reg;
    div_rise  = START_DIV && !div_prev_reg && div_armed_reg;
    div_start = (state_reg == ST_IDLE) && (op_eff == OP_DIV) && div_rise && (b_reg != '0);
    sum_w     = {1'b0, a_reg} + {1'b0, b_reg};
    diff_w    = {1'b0, a_reg} - {1'b0, b_reg};
    acc_next  = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
  end

  seq_divider #(.WIDTH(WIDTH)) u_div (
    .CLK       (CLK),
    .CLR       (CLR),
    .start     (div_start),
    .dividend  (a_reg),
    .divisor   (b_reg),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  assign BUSY = mul_busy_reg | div_busy;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_reg     <= ST_IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      op_reg        <= OP_NONE;
      mul_prev_reg  <= 1'b0;
      div_prev_reg  <= 1'b0;
      mul_armed_reg <= 1'b0;
      div_armed_reg <= 1'b0;
      mcand_reg     <= '0;
      mplier_reg    <= '0;
      acc_reg       <= '0;
      mcnt_reg      <= '0;
      result_reg    <= '0;
      mul_busy_reg  <= 1'b0;
      done_reg      <= 1'b0;
      neg_reg       <= 1'b0;
      div0_reg      <= 1'b0;
    end else begin
      mul_prev_reg <= START_MUL;
      div_prev_reg <= START_DIV;
      if (!START_MUL) mul_armed_reg <= 1'b1;
      if (!START_DIV) div_armed_reg <= 1'b1;

      if (!BUSY) begin
        if (LdA) a_reg <= SW;
        if (LdB) b_reg <= SW;
      end

      case (state_reg)
        ST_IDLE: begin
          if (op_eff == OP_ADD || op_eff == OP_SUB) begin
            op_reg    <= op_eff;
            state_reg <= ST_ARITH;
          end else if (op_eff == OP_MUL && mul_rise) begin
            op_reg       <= op_eff;
            mcand_reg    <= {{WIDTH{1'b0}}, a_reg};
            mplier_reg   <= b_reg;
            acc_reg      <= '0;
            mcnt_reg     <= '0;
            mul_busy_reg <= 1'b1;
            state_reg    <= ST_MULT;
          end else if (op_eff == OP_DIV && div_rise) begin
            op_reg    <= op_eff;
            state_reg <= ST_DIVD;
          end
        end

        ST_ARITH: begin
          if (op_reg == OP_SUB) begin
            result_reg <= {{(WIDTH-1){diff_w[WIDTH]}}, diff_w};
            neg_reg    <= (a_reg < b_reg);
          end else begin
            result_reg <= {{(WIDTH-1){1'b0}}, sum_w};
            neg_reg    <= 1'b0;
          end
          div0_reg  <= 1'b0;
          done_reg  <= 1'b1;
          state_reg <= ST_HOLD;
        end

        ST_MULT: begin
          acc_reg    <= acc_next;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          mcnt_reg   <= mcnt_reg + 1'b1;
          if (mcnt_reg == LAST) begin
            result_reg   <= acc_next;
            mul_busy_reg <= 1'b0;
            neg_reg      <= 1'b0;
            div0_reg     <= 1'b0;
            done_reg     <= 1'b1;
            state_reg    <= ST_HOLD;
          end
        end

        // Divider not running on the first DIVD cycle means B was zero at dispatch.
        ST_DIVD: begin
          if (div_done) begin
            result_reg <= {div_rem, div_quo};
            neg_reg    <= 1'b0;
            div0_reg   <= 1'b0;
            done_reg   <= 1'b1;
            state_reg  <= ST_HOLD;
          end else if (!div_busy) begin
            result_reg <= '1;
            neg_reg    <= 1'b0;
            div0_reg   <= 1'b1;
            done_reg   <= 1'b1;
            state_reg  <= ST_HOLD;
          end
        end

        ST_HOLD: begin
          if (op_eff != op_reg) begin
            done_reg  <= 1'b0;
            neg_reg   <= 1'b0;
            div0_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign RESULT = result_reg;
  assign DONE   = done_reg;
  assign NEG    = neg_reg;
  assign DIV0   = div0_reg;

endmodule

// File: tb/tb_calc_datapath.sv
// Bench for calc_datapath: directed vector table, hand-written multi-cycle
// sequences and randomized operations against an arithmetic reference model.
module tb_calc_datapath;

  localparam logic [3:0] ADD = 4'b0001;
  localparam logic [3:0] SUB = 4'b0010;
  localparam logic [3:0] MUL = 4'b0100;
  localparam logic [3:0] DIV = 4'b1000;

  logic        CLK, CLR;
  logic [7:0]  SW;
  logic        LdA, LdB;
  logic [3:0]  OP;
  logic        START_MUL, START_DIV;
  logic [15:0] RESULT;
  logic        BUSY, DONE, NEG, DIV0;

  int checks   = 0;
  int failures = 0;

  calc_datapath #(.WIDTH(8)) dut (
    .CLK(CLK), .CLR(CLR), .SW(SW), .LdA(LdA), .LdB(LdB), .OP(OP),
    .START_MUL(START_MUL), .START_DIV(START_DIV),
    .RESULT(RESULT), .BUSY(BUSY), .DONE(DONE), .NEG(NEG), .DIV0(DIV0)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  op;
    logic [15:0] res;
    logic        neg;
    logic        div0;
    int          lat;
    int          busy;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] b);
    SW = a; LdA = 1'b1; LdB = 1'b0;
    step();
    SW = b; LdA = 1'b0; LdB = 1'b1;
    step();
    LdB = 1'b0;
  endtask

  // Wait for DONE, counting edges and the cycles BUSY was seen high.
  task automatic wait_done(output int lat, output int busy_n, output bit timeout);
    lat = 0; busy_n = 0;
    do begin
      step();
      lat++;
      if (BUSY) busy_n++;
    end while (!DONE && lat < 40);
    timeout = !DONE;
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                        output logic [15:0] res, output logic neg, output logic div0,
                        output int lat, output int busy_n, output bit timeout);
    load(a, b);
    OP = op;
    if (op == MUL) START_MUL = 1'b1;
    if (op == DIV) START_DIV = 1'b1;
    wait_done(lat, busy_n, timeout);
    res = RESULT; neg = NEG; div0 = DIV0;
    START_MUL = 1'b0; START_DIV = 1'b0; OP = 4'b0000;
    step();
  endtask

  // Reference: arithmetic straight from the operation definitions.
  function automatic vec_t model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    vec_t v;
    int unsigned ua, ub;
    ua = a; ub = b;
    v.a = a; v.b = b; v.op = op; v.neg = 0; v.div0 = 0; v.lat = 2; v.busy = 0;
    case (op)
      ADD: v.res = 16'(ua + ub);
      SUB: begin v.res = 16'(ua - ub); v.neg = (ua < ub); end
      MUL: begin v.res = 16'(ua * ub); v.lat = 9; v.busy = 8; end
      default: begin
        if (ub == 0) begin v.res = 16'hFFFF; v.div0 = 1; end
        else begin v.res = {8'(ua % ub), 8'(ua / ub)}; v.lat = 9; v.busy = 8; end
      end
    endcase
    return v;
  endfunction

  task automatic check_vec(input string tag, input vec_t e);
    logic [15:0] res; logic neg, div0; int lat, busy_n; bit to;
    run_op(e.a, e.b, e.op, res, neg, div0, lat, busy_n, to);
    $display("op=%b a=%0d b=%0d result=%h neg=%b div0=%b lat=%0d busy=%0d", e.op, e.a, e.b, res, neg, div0, lat, busy_n);
    chk({tag, "_timeout"}, 32'(to), 32'd0);
    chk({tag, "_result"}, 32'(res), 32'(e.res));
    chk({tag, "_neg"}, 32'(neg), 32'(e.neg));
    chk({tag, "_div0"}, 32'(div0), 32'(e.div0));
    chk({tag, "_latency"}, 32'(lat), 32'(e.lat));
    chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(e.busy));
  endtask

  vec_t vecs[11];

  initial begin
    logic [15:0] res; logic neg, div0; int lat, busy_n; bit to; bit bad;
    vec_t e;
    logic [7:0] ra, rb;
    logic [3:0] ops[4];

    vecs[0]  = '{8'd25,  8'd17,  ADD, 16'd42,   1'b0, 1'b0, 2, 0};
    vecs[1]  = '{8'd5,   8'd9,   SUB, 16'hFFFC, 1'b1, 1'b0, 2, 0};
    vecs[2]  = '{8'd200, 8'd150, MUL, 16'h7530, 1'b0, 1'b0, 9, 8};
    vecs[3]  = '{8'd200, 8'd7,   DIV, 16'h041C, 1'b0, 1'b0, 9, 8};
    vecs[4]  = '{8'd9,   8'd0,   DIV, 16'hFFFF, 1'b0, 1'b1, 2, 0};
    vecs[5]  = '{8'd255, 8'd255, ADD, 16'h01FE, 1'b0, 1'b0, 2, 0};
    vecs[6]  = '{8'd0,   8'd255, SUB, 16'hFF01, 1'b1, 1'b0, 2, 0};
    vecs[7]  = '{8'd255, 8'd255, MUL, 16'hFE01, 1'b0, 1'b0, 9, 8};
    vecs[8]  = '{8'd255, 8'd1,   DIV, 16'h00FF, 1'b0, 1'b0, 9, 8};
    vecs[9]  = '{8'd7,   8'd200, DIV, 16'h0700, 1'b0, 1'b0, 9, 8};
    vecs[10] = '{8'd100, 8'd100, SUB, 16'h0000, 1'b0, 1'b0, 2, 0};
    ops = '{ADD, SUB, MUL, DIV};

    CLR = 1'b0; SW = '0; LdA = 0; LdB = 0; OP = 4'b0000; START_MUL = 0; START_DIV = 0;
    #23;
    chk("reset_outputs", {12'd0, RESULT, BUSY, DONE, NEG, DIV0}, 32'd0);
    @(posedge CLK); #1;
    CLR = 1'b1;
    step();

    // ADD latency: DONE low after the first edge, high after the second.
    load(8'd25, 8'd17);
    OP = ADD;
    step();
    chk("add_done_edge1", 32'(DONE), 32'd0);
    step();
    chk("add_done_edge2", 32'(DONE), 32'd1);
    chk("add_result", 32'(RESULT), 32'd42);
    OP = 4'b0000;
    step();
    chk("idle_done_low", 32'(DONE), 32'd0);
    chk("idle_result_kept", 32'(RESULT), 32'd42);

    for (int i = 0; i < 11; i++) check_vec($sformatf("vec%0d", i), vecs[i]);

    // OP switch while holding: back through IDLE, then the new operation.
    load(8'd30, 8'd40);
    OP = ADD;
    step(); step();
    chk("hold_add_result", 32'(RESULT), 32'd70);
    OP = SUB;
    step();
    chk("hold_switch_done_low", 32'(DONE), 32'd0);
    step(); step();
    $display("hold switch sub result=%h neg=%b done=%b", RESULT, NEG, DONE);
    chk("hold_switch_done", 32'(DONE), 32'd1);
    chk("hold_switch_result", 32'(RESULT), 32'hFFF6);
    chk("hold_switch_neg", 32'(NEG), 32'd1);

    // Non-one-hot opcode acts as no operation.
    OP = 4'b0011;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (DONE || BUSY) bad = 1;
    end
    $display("invalid op done/busy seen=%b result=%h", bad, RESULT);
    chk("invalid_op_idle", 32'(bad), 32'd0);
    chk("invalid_op_result_kept", 32'(RESULT), 32'hFFF6);
    OP = 4'b0000;
    step();

    // Loads and OP changes during a multiply are ignored; the later ADD uses the old operands.
    load(8'd12, 8'd13);
    OP = MUL; START_MUL = 1'b1;
    step();
    chk("mul_busy_started", 32'(BUSY), 32'd1);
    SW = 8'd3; LdA = 1'b1; LdB = 1'b1; OP = ADD;
    step();
    LdA = 1'b0; LdB = 1'b0;
    wait_done(lat, busy_n, to);
    $display("mul under disturbance result=%h lat=%0d", RESULT, lat);
    chk("mul_disturb_timeout", 32'(to), 32'd0);
    chk("mul_disturb_result", 32'(RESULT), 32'd156);
    step(); step(); step();
    $display("redispatched add result=%h done=%b", RESULT, DONE);
    chk("redispatch_add_done", 32'(DONE), 32'd1);
    chk("redispatch_add_result", 32'(RESULT), 32'd25);
    OP = 4'b0000; START_MUL = 1'b0;
    step();

    // Reset in the 4th multiply cycle, with START_MUL still held high afterwards.
    load(8'd200, 8'd150);
    OP = MUL; START_MUL = 1'b1;
    step(); step(); step(); step();
    chk("mul_busy_before_reset", 32'(BUSY), 32'd1);
    #1 CLR = 1'b0;
    #1;
    $display("async reset result=%h busy=%b done=%b", RESULT, BUSY, DONE);
    chk("async_reset_outputs", {12'd0, RESULT, BUSY, DONE, NEG, DIV0}, 32'd0);
    @(posedge CLK); #1;
    CLR = 1'b1;
    load(8'd200, 8'd150);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (BUSY || DONE) bad = 1;
    end
    chk("held_start_no_trigger", 32'(bad), 32'd0);
    START_MUL = 1'b0;
    step();
    check_vec("post_reset_mul", vecs[2]);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      e = model(ra, rb, ops[$urandom_range(0, 3)]);
      check_vec($sformatf("rand%0d", i), e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
